// File: rtl/hazard_stall_unit.sv
// ID-stage hazard/stall controller: load-use bubble, multi-cycle FP-ALU hold, mispredict flush.
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_unit #(
    parameter int unsigned FPU_LAT = 4,
    parameter int unsigned CNT_W   = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  rs1_id,
    input  logic [4:0]  rs2_id,
    input  logic [6:0]  opcode_id,
    input  logic [4:0]  rd_ex,
    input  logic [6:0]  opcode_ex,
    input  logic        MemRd_ex,
    input  logic        RegWr_ex,
    input  logic        mispredict_ex,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Flush,
    output logic        EX_Hold,
    output logic        fpu_busy,
    output logic [31:0] stall_cycles
);

    localparam logic [0:0] S_IDLE     = 1'b0;
    localparam logic [0:0] S_FPU_BUSY = 1'b1;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_FP     = 7'b1010011;

    // The entry cycle in IDLE already counts as one held cycle, and the exit cycle is unheld.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FPU_LAT - 2);

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic uses_rs1, uses_rs2, load_use, fp_ex;
    logic pc_we, ifid_we, ifid_fl, idex_fl, hold, busy;

    always_comb begin
        uses_rs1 = !((opcode_id == OP_LUI) || (opcode_id == OP_AUIPC) || (opcode_id == OP_JAL));
        uses_rs2 = (opcode_id == OP_RTYPE) || (opcode_id == OP_STORE) || (opcode_id == OP_BRANCH);
        load_use = MemRd_ex && RegWr_ex && (rd_ex != 5'd0) &&
                   ((uses_rs1 && (rd_ex == rs1_id)) || (uses_rs2 && (rd_ex == rs2_id)));
        fp_ex    = (opcode_ex == OP_FP);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        ifid_fl = 1'b0;
        idex_fl = 1'b0;
        hold    = 1'b0;
        busy    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fp_ex) begin
                    hold    = 1'b1;
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    cnt_d   = CNT_INIT;
                    state_d = S_FPU_BUSY;
                end else if (load_use) begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    idex_fl = 1'b1;
                end
            end
            S_FPU_BUSY: begin
                busy = 1'b1;
                if (cnt_q != '0) begin
                    hold    = 1'b1;
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    cnt_d   = cnt_q - 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Mispredict overrides the control outputs only; FSM sequencing is unaffected.
        if (mispredict_ex) begin
            ifid_fl = 1'b1;
            idex_fl = 1'b1;
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            hold    = 1'b0;
        end

        // Outputs must read reset values the moment rst rises, even if EX still holds an FP op.
        if (rst) begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
            ifid_fl = 1'b0;
            idex_fl = 1'b0;
            hold    = 1'b0;
            busy    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign PCWrite     = pc_we;
    assign IF_ID_Write = ifid_we;
    assign IF_ID_Flush = ifid_fl;
    assign ID_EX_Flush = idex_fl;
    assign EX_Hold     = hold;
    assign fpu_busy    = busy;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!pc_we && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed self-checking bench for hazard_stall_unit (FPU_LAT=4, CNT_W=3).
module tb_hazard_stall_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rs1_id, rs2_id, rd_ex;
    logic [6:0]  opcode_id, opcode_ex;
    logic        MemRd_ex, RegWr_ex, mispredict_ex;
    logic        PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_Hold, fpu_busy;
    logic [31:0] stall_cycles;

    int checks = 0;
    int errors = 0;

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_Hold, fpu_busy}
    localparam logic [5:0] V_IDLE    = 6'b110000;
    localparam logic [5:0] V_LDUSE   = 6'b000100;
    localparam logic [5:0] V_FPENTER = 6'b000010;
    localparam logic [5:0] V_FPHOLD  = 6'b000011;
    localparam logic [5:0] V_FPLAST  = 6'b110001;
    localparam logic [5:0] V_MISPRED = 6'b111100;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic [5:0] obs;
    assign obs = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Flush, EX_Hold, fpu_busy};

    hazard_stall_unit #(.FPU_LAT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .rs1_id(rs1_id), .rs2_id(rs2_id), .opcode_id(opcode_id),
        .rd_ex(rd_ex), .opcode_ex(opcode_ex),
        .MemRd_ex(MemRd_ex), .RegWr_ex(RegWr_ex), .mispredict_ex(mispredict_ex),
        .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .IF_ID_Flush(IF_ID_Flush),
        .ID_EX_Flush(ID_EX_Flush), .EX_Hold(EX_Hold), .fpu_busy(fpu_busy),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        rs1_id = 5'd0; rs2_id = 5'd0; opcode_id = 7'b0010011;
        rd_ex = 5'd0; opcode_ex = 7'b0010011;
        MemRd_ex = 1'b0; RegWr_ex = 1'b0; mispredict_ex = 1'b0;
    endtask

    task automatic set_lw_ex(input logic [4:0] rd);
        rd_ex = rd; opcode_ex = 7'b0000011; MemRd_ex = 1'b1; RegWr_ex = 1'b1;
    endtask

    task automatic test_reset();
        set_nop();
        set_lw_ex(5'd5);
        opcode_id = 7'b0110011; rs1_id = 5'd5;
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=%b", obs, V_IDLE);
        end
        checks++;
        if (stall_cycles !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall_cycles got=%0d exp=0", stall_cycles);
        end
        cyc();
        rst = 1'b0;
        set_nop();
        cyc();
    endtask

    task automatic test_load_use();
        set_nop();
        set_lw_ex(5'd5);
        opcode_id = 7'b0110011; rs1_id = 5'd5; rs2_id = 5'd9;
        #1;
        checks++;
        if (obs !== V_LDUSE) begin
            errors++;
            $display("FAIL load_use_rs1 got=%b exp=%b", obs, V_LDUSE);
        end
        cyc();
        MemRd_ex = 1'b0; RegWr_ex = 1'b0; rd_ex = 5'd0; opcode_ex = 7'b0010011;
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL load_use_bubble got=%b exp=%b", obs, V_IDLE);
        end
        cyc();
        set_lw_ex(5'd12);
        opcode_id = 7'b0100011; rs1_id = 5'd1; rs2_id = 5'd12;
        #1;
        checks++;
        if (obs !== V_LDUSE) begin
            errors++;
            $display("FAIL load_use_rs2_store got=%b exp=%b", obs, V_LDUSE);
        end
        cyc();
        set_nop();
        cyc();
    endtask

    task automatic test_no_false_stall();
        set_nop();
        set_lw_ex(5'd0);
        opcode_id = 7'b0110011; rs1_id = 5'd0;
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL nostall_rd0 got=%b exp=%b", obs, V_IDLE);
        end
        set_lw_ex(5'd7);
        opcode_id = 7'b0110111; rs1_id = 5'd7;
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL nostall_lui got=%b exp=%b", obs, V_IDLE);
        end
        opcode_id = 7'b0010011; rs1_id = 5'd3; rs2_id = 5'd7;
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL nostall_addi_rs2 got=%b exp=%b", obs, V_IDLE);
        end
        RegWr_ex = 1'b0; opcode_id = 7'b0110011; rs1_id = 5'd7;
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL nostall_no_regwr got=%b exp=%b", obs, V_IDLE);
        end
        set_nop();
        cyc();
    endtask

    task automatic test_fp_hold();
        logic [5:0] exp_seq [4];
        exp_seq[0] = V_FPENTER; exp_seq[1] = V_FPHOLD;
        exp_seq[2] = V_FPHOLD;  exp_seq[3] = V_FPLAST;
        set_nop();
        opcode_ex = 7'b1010011;
        set_lw_ex(5'd0);
        opcode_ex = 7'b1010011; MemRd_ex = 1'b0; RegWr_ex = 1'b0;
        for (int op = 0; op < 2; op++) begin
            for (int c = 0; c < 4; c++) begin
                #1;
                checks++;
                if (obs !== exp_seq[c]) begin
                    errors++;
                    $display("FAIL fp_hold op%0d cyc%0d got=%b exp=%b", op, c + 1, obs, exp_seq[c]);
                end
                cyc();
            end
        end
        set_nop();
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL fp_hold_after got=%b exp=%b", obs, V_IDLE);
        end
        cyc();
    endtask

    task automatic test_fp_masks_load_use();
        set_nop();
        opcode_ex = 7'b1010011;
        cyc();
        rd_ex = 5'd5; MemRd_ex = 1'b1; RegWr_ex = 1'b1;
        opcode_id = 7'b0110011; rs1_id = 5'd5;
        #1;
        checks++;
        if (obs !== V_FPHOLD) begin
            errors++;
            $display("FAIL fp_masks_load_use got=%b exp=%b", obs, V_FPHOLD);
        end
        cyc(); cyc();
        set_nop();
        cyc();
    endtask

    task automatic test_priority();
        set_nop();
        set_lw_ex(5'd5);
        opcode_id = 7'b0110011; rs1_id = 5'd5; mispredict_ex = 1'b1;
        #1;
        checks++;
        if (obs !== V_MISPRED) begin
            errors++;
            $display("FAIL mispredict_over_load_use got=%b exp=%b", obs, V_MISPRED);
        end
        cyc();
        set_nop();
        opcode_ex = 7'b1010011;
        #1;
        checks++;
        if (obs !== V_FPENTER) begin
            errors++;
            $display("FAIL rst_pulse_fp_enter got=%b exp=%b", obs, V_FPENTER);
        end
        cyc();
        rst = 1'b1;
        #1;
        checks++;
        if (obs !== V_IDLE) begin
            errors++;
            $display("FAIL rst_pulse_async got=%b exp=%b", obs, V_IDLE);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (obs !== V_FPENTER) begin
            errors++;
            $display("FAIL rst_resume_idle got=%b exp=%b", obs, V_FPENTER);
        end
        cyc();
        #1;
        checks++;
        if (obs !== V_FPHOLD) begin
            errors++;
            $display("FAIL rst_resume_busy got=%b exp=%b", obs, V_FPHOLD);
        end
        cyc(); cyc();
        #1;
        checks++;
        if (obs !== V_FPLAST) begin
            errors++;
            $display("FAIL rst_resume_last got=%b exp=%b", obs, V_FPLAST);
        end
        cyc();
        set_nop();
        cyc();
    endtask

    task automatic test_perf();
        logic [31:0] exp_cnt;
        rst = 1'b1;
        #1;
        rst = 1'b0;
        set_nop();
        cyc();
        set_lw_ex(5'd5);
        opcode_id = 7'b0110011; rs1_id = 5'd5;
        cyc();
        set_nop();
        exp_cnt = PERF ? 32'd1 : 32'd0;
        checks++;
        if (stall_cycles !== exp_cnt) begin
            errors++;
            $display("FAIL perf_after_load_use got=%0d exp=%0d", stall_cycles, exp_cnt);
        end
        cyc();
        opcode_ex = 7'b1010011;
        cyc(); cyc(); cyc(); cyc();
        set_nop();
        cyc(); cyc();
        exp_cnt = PERF ? 32'd4 : 32'd0;
        checks++;
        if (stall_cycles !== exp_cnt) begin
            errors++;
            $display("FAIL perf_total got=%0d exp=%0d", stall_cycles, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_fp_hold();
        test_fp_masks_load_use();
        test_priority();
        test_perf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
